// File: rtl/uart_tx_sched.sv
// Round-robin arbiter that shares one 8N1 serial TX line among NUM_REQ byte requesters.
// Bit pacing comes from an external baud generator whose enable this block owns.
module uart_tx_sched #(
    parameter  int NUM_REQ    = 4,
    parameter  int DATA_WIDTH = 8,
    parameter  int STOP_BITS  = 1,
    localparam int ID_W       = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                          i_clk,
    input  logic                          i_rst_n,
    input  logic [NUM_REQ-1:0]            i_req,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] i_data,
    output logic [NUM_REQ-1:0]            o_ack,
    output logic                          o_baud_enable,
    input  logic                          i_baud_tick,
    output logic                          o_txd,
    output logic                          o_busy,
    output logic [ID_W-1:0]               o_grant_id
);

    localparam int CNT_W = $clog2(DATA_WIDTH + 1);
    localparam int SUM_W = ID_W + 1;

    typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

    state_t                r_state, w_state_nxt;
    logic [DATA_WIDTH-1:0] r_shift, w_shift_nxt;
    logic [CNT_W-1:0]      r_cnt, w_cnt_nxt;
    logic [ID_W-1:0]       r_ptr, w_ptr_nxt;
    logic [ID_W-1:0]       r_grant, w_grant_nxt;
    logic [NUM_REQ-1:0]    r_ack, w_ack_nxt;
    logic                  r_txd, w_txd_nxt;
    logic                  r_ben, w_ben_nxt;
    logic                  r_busy, w_busy_nxt;

    logic [2*NUM_REQ-1:0]  w_dbl;
    logic [NUM_REQ-1:0]    w_rot;
    logic [ID_W-1:0]       w_off;
    logic [SUM_W-1:0]      w_sum;
    logic [ID_W-1:0]       w_sel;
    logic                  w_found;
    logic [DATA_WIDTH-1:0] w_sel_data;

    // Rotate requests so r_ptr sits at bit 0; the lowest set bit is the next winner.
    always_comb begin
        w_dbl   = {i_req, i_req} >> r_ptr;
        w_rot   = w_dbl[NUM_REQ-1:0];
        w_found = |i_req;
        w_off   = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (w_rot[k]) w_off = ID_W'(k);
        end
        w_sum = {1'b0, r_ptr} + {1'b0, w_off};
        if (w_sum >= SUM_W'(NUM_REQ)) w_sum = w_sum - SUM_W'(NUM_REQ);
        w_sel = w_sum[ID_W-1:0];
        w_sel_data = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (k == int'(w_sel)) w_sel_data = i_data[k*DATA_WIDTH +: DATA_WIDTH];
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_shift_nxt = r_shift;
        w_cnt_nxt   = r_cnt;
        w_ptr_nxt   = r_ptr;
        w_grant_nxt = r_grant;
        w_ack_nxt   = '0;
        w_txd_nxt   = r_txd;
        w_ben_nxt   = r_ben;
        w_busy_nxt  = r_busy;
        case (r_state)
            S_IDLE: begin
                if (w_found) begin
                    w_shift_nxt = w_sel_data;
                    w_ack_nxt   = NUM_REQ'(1) << w_sel;
                    w_grant_nxt = w_sel;
                    w_ptr_nxt   = (int'(w_sel) == NUM_REQ - 1) ? '0 : w_sel + 1'b1;
                    w_txd_nxt   = 1'b0;
                    w_ben_nxt   = 1'b1;
                    w_busy_nxt  = 1'b1;
                    w_state_nxt = S_START;
                end
            end
            S_START: begin
                if (i_baud_tick) begin
                    w_txd_nxt   = r_shift[0];
                    w_cnt_nxt   = '0;
                    w_state_nxt = S_DATA;
                end
            end
            S_DATA: begin
                if (i_baud_tick) begin
                    if (r_cnt == CNT_W'(DATA_WIDTH - 1)) begin
                        w_txd_nxt   = 1'b1;
                        w_cnt_nxt   = '0;
                        w_state_nxt = S_STOP;
                    end else begin
                        w_shift_nxt = r_shift >> 1;
                        w_txd_nxt   = r_shift[1];
                        w_cnt_nxt   = r_cnt + 1'b1;
                    end
                end
            end
            S_STOP: begin
                if (i_baud_tick) begin
                    if (r_cnt == CNT_W'(STOP_BITS - 1)) begin
                        w_ben_nxt   = 1'b0;
                        w_busy_nxt  = 1'b0;
                        w_state_nxt = S_IDLE;
                    end else begin
                        w_cnt_nxt = r_cnt + 1'b1;
                    end
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state <= S_IDLE;
            r_shift <= '0;
            r_cnt   <= '0;
            r_ptr   <= '0;
            r_grant <= '0;
            r_ack   <= '0;
            r_txd   <= 1'b1;
            r_ben   <= 1'b0;
            r_busy  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_shift <= w_shift_nxt;
            r_cnt   <= w_cnt_nxt;
            r_ptr   <= w_ptr_nxt;
            r_grant <= w_grant_nxt;
            r_ack   <= w_ack_nxt;
            r_txd   <= w_txd_nxt;
            r_ben   <= w_ben_nxt;
            r_busy  <= w_busy_nxt;
        end
    end

    assign o_ack         = r_ack;
    assign o_baud_enable = r_ben;
    assign o_txd         = r_txd;
    assign o_busy        = r_busy;
    assign o_grant_id    = r_grant;

endmodule

// File: tb/tb_uart_tx_sched.sv
// Directed bench for uart_tx_sched: expected grant ids and txd bits are queued
// when stimulus is applied and popped as grants and baud ticks occur.
module tb_uart_tx_sched;

    logic        clk = 1'b0;
    logic        rst_n, tick, ben, txd, busy;
    logic [3:0]  req, ack;
    logic [31:0] data;
    logic [1:0]  gid;

    logic        tick2, ben2, txd2, busy2;
    logic [3:0]  req2, ack2;
    logic [31:0] data2;
    logic [1:0]  gid2;

    int   checks = 0;
    int   errors = 0;
    logic sb_bit[$];
    int   sb_id[$];

    always #5 clk = ~clk;

    uart_tx_sched #(.NUM_REQ(4), .DATA_WIDTH(8), .STOP_BITS(1)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_req(req), .i_data(data), .o_ack(ack),
        .o_baud_enable(ben), .i_baud_tick(tick), .o_txd(txd), .o_busy(busy),
        .o_grant_id(gid)
    );

    uart_tx_sched #(.NUM_REQ(4), .DATA_WIDTH(8), .STOP_BITS(2)) dut2 (
        .i_clk(clk), .i_rst_n(rst_n), .i_req(req2), .i_data(data2), .o_ack(ack2),
        .o_baud_enable(ben2), .i_baud_tick(tick2), .o_txd(txd2), .o_busy(busy2),
        .o_grant_id(gid2)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clk1();
        @(posedge clk);
        #1;
    endtask

    // Edge that should grant the head of sb_id; queues the frame's txd bits.
    task automatic grant_chk();
        int         id;
        logic [3:0] exp_ack;
        logic [7:0] b;
        id      = sb_id.pop_front();
        b       = data[id*8 +: 8];
        exp_ack = 4'b0001 << id;
        clk1();
        chk("grant_ack", ack, exp_ack);
        chk("grant_id", gid, id);
        chk("start_txd", txd, 1'b0);
        chk("start_busy", busy, 1'b1);
        chk("start_ben", ben, 1'b1);
        for (int i = 0; i < 8; i++) sb_bit.push_back(b[i]);
        repeat (2) sb_bit.push_back(1'b1);
    endtask

    // One idle clock then one baud tick; compares txd against the scoreboard head.
    task automatic tick_step(input bit pulse3);
        logic e;
        e = sb_bit.pop_front();
        if (pulse3) req[3] = 1'b1;
        clk1();
        if (pulse3) req[3] = 1'b0;
        chk("gap_ack", ack, 4'b0000);
        tick = 1'b1;
        clk1();
        tick = 1'b0;
        chk("txd_bit", txd, e);
        chk("tick_ack", ack, 4'b0000);
        chk("frame_busy", busy, sb_bit.size() != 0);
        chk("frame_ben", ben, sb_bit.size() != 0);
    endtask

    task automatic run_frame(input bit pulse3);
        while (sb_bit.size() > 0) tick_step(pulse3 && sb_bit.size() == 6);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        clk1();
        clk1();
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0; req = 4'b1111; data = '0; tick = 1'b0;
        req2 = '0; data2 = '0; tick2 = 1'b0;

        // Reset with all requests asserted
        clk1();
        clk1();
        chk("rst_txd", txd, 1'b1);
        chk("rst_ack", ack, 4'b0000);
        chk("rst_busy", busy, 1'b0);
        chk("rst_ben", ben, 1'b0);
        chk("rst_gid", gid, 2'd0);
        rst_n = 1'b1;
        req   = 4'b0000;
        clk1();
        chk("idle_ack", ack, 4'b0000);

        // Single frame from requester 2
        req = 4'b0100;
        data[23:16] = 8'hA5;
        sb_id.push_back(2);
        grant_chk();
        req = 4'b0000;
        run_frame(1'b0);

        // Requester 0 (pointer wraps past 3) while req[3] is briefly pulsed
        req = 4'b0001;
        data[7:0] = 8'h3C;
        sb_id.push_back(0);
        grant_chk();
        req = 4'b0000;
        run_frame(1'b1);
        repeat (3) begin
            clk1();
            chk("withdrawn_ack", ack, 4'b0000);
            chk("withdrawn_busy", busy, 1'b0);
            chk("withdrawn_txd", txd, 1'b1);
        end

        // Round robin with req=1011 held continuously
        do_reset();
        data = 32'h5A_77_C3_81;
        req  = 4'b1011;
        foreach (sb_id[i]) sb_id.delete(i);
        sb_id.push_back(0); sb_id.push_back(1); sb_id.push_back(3);
        sb_id.push_back(0); sb_id.push_back(1); sb_id.push_back(3);
        repeat (6) begin
            grant_chk();
            run_frame(1'b0);
        end
        req = 4'b0000;
        clk1();
        chk("rr_done_ack", ack, 4'b0000);

        // Reset mid-frame after the third data tick
        req = 4'b0010;
        data[15:8] = 8'h96;
        sb_id.push_back(1);
        grant_chk();
        req = 4'b0000;
        repeat (4) tick_step(1'b0);
        rst_n = 1'b0;
        clk1();
        chk("midrst_txd", txd, 1'b1);
        chk("midrst_busy", busy, 1'b0);
        chk("midrst_ben", ben, 1'b0);
        chk("midrst_ack", ack, 4'b0000);
        sb_bit.delete();
        rst_n = 1'b1;
        req = 4'b1010;
        data[15:8] = 8'h4E;
        sb_id.push_back(1);
        grant_chk();
        req = 4'b0000;
        run_frame(1'b0);

        // Two stop bits, all-ones byte: 11 ticks, enable drops on the last one
        req2 = 4'b0001;
        data2[7:0] = 8'hFF;
        clk1();
        chk("sb2_ack", ack2, 4'b0001);
        chk("sb2_start", txd2, 1'b0);
        req2 = 4'b0000;
        for (int i = 0; i < 11; i++) begin
            clk1();
            tick2 = 1'b1;
            clk1();
            tick2 = 1'b0;
            chk("sb2_txd", txd2, 1'b1);
            chk("sb2_ben", ben2, i < 10);
            chk("sb2_busy", busy2, i < 10);
        end
        tick2 = 1'b1;
        clk1();
        tick2 = 1'b0;
        clk1();
        chk("stray_txd", txd2, 1'b1);
        chk("stray_busy", busy2, 1'b0);
        chk("stray_ben", ben2, 1'b0);
        chk("stray_ack", ack2, 4'b0000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
